ama_riscv_wb_stage: RTL

- Writeback stage between the memory stage and the register file.
- Registers memory-stage results and selects the writeback source: ALU, load data, PC+4 or CSR.
- Aligns and sign/zero-extends load data, and drives the register-file write port, including the paired-register write.
- Exports the same write as a forwarding source, and holds load data across stalls so each instruction writes the register file exactly once.

---
 rtl/ama_riscv_wb_stage.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ama_riscv_wb_stage.sv
// Writeback stage: registers memory-stage results, aligns/extends loads and drives the RF write port.
// Optional retired-instruction counter enabled by defining AMA_RISCV_WB_RETIRE_CNT_EN.
module ama_riscv_wb_stage #(
    parameter int ARCH_W = 32,
    parameter int RF_AW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic [RF_AW-1:0]  mem_rd,
    input  logic              mem_rd_we,
    input  logic              mem_rdp_we,
    input  logic [1:0]        mem_wb_sel,
    input  logic [ARCH_W-1:0] mem_alu,
    input  logic [ARCH_W-1:0] mem_alu_hi,
    input  logic [ARCH_W-1:0] mem_pc,
    input  logic [ARCH_W-1:0] mem_csr,
    input  logic [2:0]        mem_ld_f3,
    input  logic [1:0]        mem_ld_off,
    input  logic [ARCH_W-1:0] dmem_rdata,
    output logic              rf_we,
    output logic              rf_we_p,
    output logic [RF_AW-1:0]  rf_addr_d,
    output logic [ARCH_W-1:0] rf_data_d,
    output logic [ARCH_W-1:0] rf_data_dp,
    output logic              fwd_we,
    output logic [RF_AW-1:0]  fwd_rd,
    output logic [ARCH_W-1:0] fwd_data,
    output logic              err_rdp
`ifdef AMA_RISCV_WB_RETIRE_CNT_EN
    ,
    output logic [63:0]       retire_cnt
`endif
);

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_PC4 = 2'd2;
    localparam logic [1:0] SEL_CSR = 2'd3;

    logic              r_valid;
    logic [RF_AW-1:0]  r_rd;
    logic              r_rd_we;
    logic              r_rdp_we;
    logic [1:0]        r_wb_sel;
    logic [ARCH_W-1:0] r_alu;
    logic [ARCH_W-1:0] r_alu_hi;
    logic [ARCH_W-1:0] r_pc;
    logic [ARCH_W-1:0] r_csr;
    logic [2:0]        r_ld_f3;
    logic [1:0]        r_ld_off;
    logic              r_hold_vld;
    logic [ARCH_W-1:0] r_hold_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_rd        <= '0;
            r_rd_we     <= 1'b0;
            r_rdp_we    <= 1'b0;
            r_wb_sel    <= SEL_ALU;
            r_alu       <= '0;
            r_alu_hi    <= '0;
            r_pc        <= '0;
            r_csr       <= '0;
            r_ld_f3     <= '0;
            r_ld_off    <= '0;
            r_hold_vld  <= 1'b0;
            r_hold_data <= '0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_hold_vld <= 1'b0;
        end else if (stall) begin
            // Latch the DMEM word only once: later stall cycles may see it change.
            if (r_valid && (r_wb_sel == SEL_MEM) && !r_hold_vld) begin
                r_hold_data <= dmem_rdata;
                r_hold_vld  <= 1'b1;
            end
        end else begin
            r_valid    <= mem_valid;
            r_rd       <= mem_rd;
            r_rd_we    <= mem_rd_we;
            r_rdp_we   <= mem_rdp_we;
            r_wb_sel   <= mem_wb_sel;
            r_alu      <= mem_alu;
            r_alu_hi   <= mem_alu_hi;
            r_pc       <= mem_pc;
            r_csr      <= mem_csr;
            r_ld_f3    <= mem_ld_f3;
            r_ld_off   <= mem_ld_off;
            r_hold_vld <= 1'b0;
        end
    end

    logic [ARCH_W-1:0] w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [ARCH_W-1:0] w_load;
    logic [ARCH_W-1:0] w_data;
    logic              w_we;
    logic              w_pair_req;
    logic              w_rd_x31;

    always_comb begin
        w_word = r_hold_vld ? r_hold_data : dmem_rdata;
        case (r_ld_off)
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half = r_ld_off[1] ? w_word[31:16] : w_word[15:0];
        case (r_ld_f3)
            3'b000:  w_load = {{(ARCH_W-8){w_byte[7]}}, w_byte};
            3'b100:  w_load = {{(ARCH_W-8){1'b0}}, w_byte};
            3'b001:  w_load = {{(ARCH_W-16){w_half[15]}}, w_half};
            3'b101:  w_load = {{(ARCH_W-16){1'b0}}, w_half};
            3'b010:  w_load = w_word;
            default: w_load = '0;
        endcase
        case (r_wb_sel)
            SEL_ALU: w_data = r_alu;
            SEL_MEM: w_data = w_load;
            SEL_PC4: w_data = r_pc + ARCH_W'(4);
            default: w_data = r_csr;
        endcase
    end

    assign w_we       = r_valid && r_rd_we && !stall && (r_rd != '0);
    assign w_pair_req = w_we && r_rdp_we && (r_wb_sel == SEL_ALU);
    assign w_rd_x31   = (r_rd == RF_AW'(31));

    assign rf_we      = w_we;
    assign rf_we_p    = w_pair_req && !w_rd_x31;
    assign err_rdp    = w_pair_req && w_rd_x31;
    assign rf_addr_d  = r_rd;
    assign rf_data_d  = w_data;
    assign rf_data_dp = r_alu_hi;
    assign fwd_we     = w_we;
    assign fwd_rd     = r_rd;
    assign fwd_data   = w_data;

`ifdef AMA_RISCV_WB_RETIRE_CNT_EN
    logic [63:0] r_retire_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire_cnt <= '0;
        end else if (r_valid && !stall && !flush) begin
            r_retire_cnt <= r_retire_cnt + 64'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`endif

endmodule
